// File: rtl/trip_stat_ctrl_pkg.sv
// trip_stat_ctrl_pkg
// Shared definitions for the trip statistics controller: FSM state and
// display-item encodings, default datapath widths, and the display-cycling
// helper used by the controller.
package trip_stat_ctrl_pkg;

    localparam int DEF_WIDTH  = 12;   // speed sample width (tracker width)
    localparam int DEF_TIME_W = 16;   // trip-time counter width, seconds

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RIDE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DISP_SPEED = 2'd0,
        DISP_MAX   = 2'd1,
        DISP_TIME  = 2'd2
    } disp_t;

    // Next display item in the SPEED -> MAX -> TIME -> SPEED ring.
    function automatic disp_t next_disp(input disp_t cur);
        case (cur)
            DISP_SPEED: return DISP_MAX;
            DISP_MAX:   return DISP_TIME;
            default:    return DISP_SPEED;
        endcase
    endfunction

endpackage

// File: rtl/trip_stat_ctrl_if.sv
// trip_stat_ctrl_if
// Bundles every signal between the controller and its neighbours (speed
// unit, button debouncer, max-speed tracker, display driver).
//   speed/speed_vld : speed sample and its one-cycle strobe
//   tick_1s         : one-cycle strobe per second
//   btn_mode/btn_clr: debounced one-cycle button pulses
//   max_val         : tracker output looped back
//   trk_speed/trk_r : tracker sample input and synchronous clear
//   trip_time       : seconds spent riding
//   disp_sel/disp_val: selected display item and its value
//   state_o         : 0=STOP, 1=RIDE, 2=CLEAR
// master = surrounding system, slave = controller.
interface trip_stat_ctrl_if
    import trip_stat_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int TIME_W = DEF_TIME_W
);
    logic [WIDTH-1:0]  speed;
    logic              speed_vld;
    logic              tick_1s;
    logic              btn_mode;
    logic              btn_clr;
    logic [WIDTH-1:0]  max_val;
    logic [WIDTH-1:0]  trk_speed;
    logic              trk_r;
    logic [TIME_W-1:0] trip_time;
    logic [1:0]        disp_sel;
    logic [TIME_W-1:0] disp_val;
    logic [1:0]        state_o;

    modport master (
        output speed, speed_vld, tick_1s, btn_mode, btn_clr, max_val,
        input  trk_speed, trk_r, trip_time, disp_sel, disp_val, state_o
    );

    modport slave (
        input  speed, speed_vld, tick_1s, btn_mode, btn_clr, max_val,
        output trk_speed, trk_r, trip_time, disp_sel, disp_val, state_o
    );
endinterface

// File: rtl/trip_stat_ctrl_sat_counter.sv
// trip_stat_ctrl_sat_counter (sat_counter)
// Up-counter that sticks at its all-ones value.
//   clk  : clock
//   srst : synchronous active-high reset
//   en   : count enable
//   clr  : synchronous clear, wins over en
//   q    : count value (registered)
module trip_stat_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);
    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            q_reg <= '0;
        end else if (en && (q_reg != '1)) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/trip_stat_ctrl.sv
// trip_stat_ctrl
// Sequences the max-speed tracker and trip-time accounting of the bike
// computer: gates speed samples into the tracker, issues its clear, runs the
// STOP/RIDE/CLEAR machine with auto-pause and picks the displayed statistic.
//   clk : system clock
//   r   : synchronous active-high reset (overrides everything)
//   bus : trip_stat_ctrl_if.slave, see the interface header for signals
// All outputs are registered.
module trip_stat_ctrl
    import trip_stat_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIME_W  = DEF_TIME_W,
    parameter int STOP_N  = 3,
    parameter int CLR_CYC = 2
) (
    input  logic              clk,
    input  logic              r,
    trip_stat_ctrl_if.slave   bus
);
    localparam int ZW = $clog2(STOP_N + 1);
    localparam int CW = $clog2(CLR_CYC + 1);

    state_t            state_reg,     state_next;
    logic [ZW-1:0]     zrun_reg,      zrun_next;
    logic [CW-1:0]     clr_cnt_reg,   clr_cnt_next;
    logic [WIDTH-1:0]  trk_speed_reg, trk_speed_next;
    logic              trk_r_reg;
    disp_t             disp_sel_reg,  disp_sel_next;
    logic [TIME_W-1:0] disp_val_reg,  disp_val_next;
    logic [TIME_W-1:0] trip_time;
    logic              time_en;
    logic              time_clr;
    logic              speed_zero;

    // Speed-width values resized to the display width.
    logic [TIME_W-1:0] spd_fit;
    logic [TIME_W-1:0] max_fit;

    generate
        if (WIDTH >= TIME_W) begin : g_trunc
            assign spd_fit = trk_speed_reg[TIME_W-1:0];
            assign max_fit = bus.max_val[TIME_W-1:0];
        end else begin : g_ext
            assign spd_fit = {{(TIME_W-WIDTH){1'b0}}, trk_speed_reg};
            assign max_fit = {{(TIME_W-WIDTH){1'b0}}, bus.max_val};
        end
    endgenerate

    assign speed_zero = (bus.speed == '0);

    always_comb begin
        state_next     = state_reg;
        zrun_next      = zrun_reg;
        clr_cnt_next   = clr_cnt_reg;
        trk_speed_next = trk_speed_reg;
        disp_sel_next  = disp_sel_reg;
        time_en        = 1'b0;
        time_clr       = 1'b0;

        if (bus.btn_clr) begin
            // clr_cnt holds the CLEAR cycles remaining after the first one,
            // so a btn_clr inside CLEAR simply restarts the window.
            state_next     = ST_CLEAR;
            clr_cnt_next   = CW'(CLR_CYC - 1);
            zrun_next      = '0;
            trk_speed_next = '0;
            time_clr       = 1'b1;
        end else begin
            if (bus.btn_mode && (state_reg != ST_CLEAR)) begin
                disp_sel_next = next_disp(disp_sel_reg);
            end

            case (state_reg)
                ST_STOP: begin
                    if (bus.speed_vld) begin
                        trk_speed_next = bus.speed;
                        if (!speed_zero) begin
                            state_next = ST_RIDE;
                            zrun_next  = '0;
                        end
                    end
                end
                ST_RIDE: begin
                    // A tick on the RIDE->STOP cycle still counts.
                    time_en = bus.tick_1s;
                    if (bus.speed_vld) begin
                        trk_speed_next = bus.speed;
                        if (!speed_zero) begin
                            zrun_next = '0;
                        end else if (zrun_reg == ZW'(STOP_N - 1)) begin
                            state_next = ST_STOP;
                            zrun_next  = '0;
                        end else begin
                            zrun_next = zrun_reg + 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_reg == '0) begin
                        state_next = ST_STOP;
                    end else begin
                        clr_cnt_next = clr_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_next = ST_STOP;
                end
            endcase
        end

        case (disp_sel_reg)
            DISP_SPEED: disp_val_next = spd_fit;
            DISP_MAX:   disp_val_next = max_fit;
            DISP_TIME:  disp_val_next = trip_time;
            default:    disp_val_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_reg     <= ST_STOP;
            zrun_reg      <= '0;
            clr_cnt_reg   <= '0;
            trk_speed_reg <= '0;
            trk_r_reg     <= 1'b0;
            disp_sel_reg  <= DISP_SPEED;
            disp_val_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            zrun_reg      <= zrun_next;
            clr_cnt_reg   <= clr_cnt_next;
            trk_speed_reg <= trk_speed_next;
            // The tracker clear is high exactly while the FSM sits in CLEAR.
            trk_r_reg     <= (state_next == ST_CLEAR);
            disp_sel_reg  <= disp_sel_next;
            disp_val_reg  <= disp_val_next;
        end
    end

    trip_stat_ctrl_sat_counter #(.W(TIME_W)) u_trip_time (
        .clk  (clk),
        .srst (r),
        .en   (time_en),
        .clr  (time_clr),
        .q    (trip_time)
    );

    assign bus.trk_speed = trk_speed_reg;
    assign bus.trk_r     = trk_r_reg;
    assign bus.trip_time = trip_time;
    assign bus.disp_sel  = disp_sel_reg;
    assign bus.disp_val  = disp_val_reg;
    assign bus.state_o   = state_reg;
endmodule

// File: tb/tb_trip_stat_ctrl.sv
// tb_trip_stat_ctrl
// Self-checking bench for trip_stat_ctrl. Two instances share one stimulus
// stream: the default one (TIME_W=16) and a narrow one (TIME_W=4) used to
// observe trip-time saturation. A behavioural max-speed tracker closes the
// max_val loop, and a cycle-level reference model of the controller rules
// supplies every expected value.
module tb_trip_stat_ctrl;
    import trip_stat_ctrl_pkg::*;

    localparam int WIDTH   = 12;
    localparam int TIME_W  = 16;
    localparam int TW4     = 4;
    localparam int STOP_N  = 3;
    localparam int CLR_CYC = 2;

    logic clk = 1'b0;
    logic r;
    always #5 clk = ~clk;

    trip_stat_ctrl_if #(.WIDTH(WIDTH), .TIME_W(TIME_W)) bus ();
    trip_stat_ctrl_if #(.WIDTH(WIDTH), .TIME_W(TW4))    bus4 ();

    trip_stat_ctrl #(.WIDTH(WIDTH), .TIME_W(TIME_W), .STOP_N(STOP_N), .CLR_CYC(CLR_CYC)) dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    trip_stat_ctrl #(.WIDTH(WIDTH), .TIME_W(TW4), .STOP_N(STOP_N), .CLR_CYC(CLR_CYC)) dut4 (
        .clk (clk),
        .r   (r),
        .bus (bus4)
    );

    // Max-speed tracker stand-in: sync clear by r or trk_r, else keep the max.
    logic [WIDTH-1:0] trk_max;
    always @(posedge clk) begin
        if (r || bus.trk_r) trk_max <= '0;
        else if (bus.trk_speed > trk_max) trk_max <= bus.trk_speed;
    end
    assign bus.max_val  = trk_max;
    assign bus4.max_val = trk_max;
    assign bus4.speed     = bus.speed;
    assign bus4.speed_vld = bus.speed_vld;
    assign bus4.tick_1s   = bus.tick_1s;
    assign bus4.btn_mode  = bus.btn_mode;
    assign bus4.btn_clr   = bus.btn_clr;

    int checks = 0;
    int errors = 0;

    // Reference model state (0=STOP, 1=RIDE, 2=CLEAR).
    int m_state = 0, m_zeros = 0, m_clr_left = 0, m_spd = 0;
    int m_time = 0, m_time4 = 0, m_sel = 0, m_disp = 0, m_max = 0;

    // One clock edge of the controller rules, applied to the current inputs.
    task automatic model_step();
        int o_state, o_spd, o_time, o_sel, o_max;
        o_state = m_state; o_spd = m_spd; o_time = m_time;
        o_sel = m_sel; o_max = m_max;
        if (r) begin
            m_state = 0; m_zeros = 0; m_clr_left = 0; m_spd = 0;
            m_time = 0; m_time4 = 0; m_sel = 0; m_disp = 0; m_max = 0;
        end else begin
            // Tracker and display register what is visible before the edge.
            m_max  = (o_state == 2) ? 0 : ((o_spd > o_max) ? o_spd : o_max);
            m_disp = (o_sel == 0) ? o_spd : ((o_sel == 1) ? o_max : o_time);
            if (bus.btn_clr) begin
                m_state = 2; m_clr_left = CLR_CYC; m_spd = 0;
                m_time = 0; m_time4 = 0; m_zeros = 0;
            end else begin
                if (bus.btn_mode && o_state != 2) m_sel = (m_sel + 1) % 3;
                if (o_state == 2) begin
                    m_clr_left = m_clr_left - 1;
                    if (m_clr_left == 0) m_state = 0;
                end else begin
                    if (o_state == 1 && bus.tick_1s) begin
                        if (m_time < (1 << TIME_W) - 1) m_time = m_time + 1;
                        if (m_time4 < (1 << TW4) - 1) m_time4 = m_time4 + 1;
                    end
                    if (bus.speed_vld) begin
                        m_spd = int'(bus.speed);
                        if (o_state == 0) begin
                            if (bus.speed != 0) begin
                                m_state = 1; m_zeros = 0;
                            end
                        end else if (bus.speed == 0) begin
                            m_zeros = m_zeros + 1;
                            if (m_zeros == STOP_N) begin
                                m_state = 0; m_zeros = 0;
                            end
                        end else begin
                            m_zeros = 0;
                        end
                    end
                end
            end
        end
    endtask

    // Advance one clock with the inputs currently driven, then drop strobes.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        r = 1'b0;
        bus.speed_vld = 1'b0;
        bus.tick_1s   = 1'b0;
        bus.btn_mode  = 1'b0;
        bus.btn_clr   = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b1;
        bus.speed = WIDTH'($urandom);
        bus.speed_vld = 1'b1; bus.tick_1s = 1'b1; bus.btn_mode = 1'b1;
        tick();
        r = 1'b1; bus.btn_clr = 1'b1;
        tick();
        checks++;
        if (bus.state_o !== 2'd0 || bus.trk_speed !== '0 || bus.trk_r !== 1'b0 ||
            bus.trip_time !== '0 || bus.disp_sel !== 2'd0 || bus.disp_val !== '0 ||
            bus4.trip_time !== '0) begin
            errors++;
            $display("FAIL reset: got state=%0d trk_speed=%0d trk_r=%0d time=%0d sel=%0d val=%0d, expected all 0",
                     bus.state_o, bus.trk_speed, bus.trk_r, bus.trip_time, bus.disp_sel, bus.disp_val);
        end
        $display("reset: state=%0d trip_time=%0d", bus.state_o, bus.trip_time);
    endtask

    task automatic test_ride_start();
        bus.speed = 12'd25; bus.speed_vld = 1'b1; bus.btn_mode = 1'b1;
        tick();
        checks++;
        if (bus.state_o !== 2'd1 || bus.trk_speed !== 12'd25) begin
            errors++;
            $display("FAIL ride_start: got state=%0d trk_speed=%0d, expected 1 and 25", bus.state_o, bus.trk_speed);
        end
        tick();
        checks++;
        if (bus.max_val !== 12'd25) begin
            errors++;
            $display("FAIL tracker_latency: got max=%0d expected 25", bus.max_val);
        end
        tick();
        checks++;
        if (bus.disp_sel !== 2'd1 || bus.disp_val !== 16'd25) begin
            errors++;
            $display("FAIL disp_max_latency: got sel=%0d val=%0d expected 1 and 25", bus.disp_sel, bus.disp_val);
        end
        $display("ride_start: state=%0d trk_speed=%0d disp_val=%0d", bus.state_o, bus.trk_speed, bus.disp_val);
    endtask

    task automatic test_trip_time();
        for (int i = 0; i < 5; i++) begin
            bus.tick_1s = 1'b1;
            tick();
            tick();
        end
        checks++;
        if (bus.trip_time !== 16'd5) begin
            errors++;
            $display("FAIL trip_time_count: got %0d expected 5", bus.trip_time);
        end
        for (int i = 0; i < 3; i++) begin
            bus.speed = '0; bus.speed_vld = 1'b1;
            tick();
            checks++;
            if (bus.state_o !== 2'(m_state) || m_state != ((i < 2) ? 1 : 0)) begin
                errors++;
                $display("FAIL auto_pause[%0d]: got state=%0d expected %0d", i, bus.state_o, (i < 2) ? 1 : 0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus.tick_1s = 1'b1;
            tick();
        end
        checks++;
        if (bus.trip_time !== 16'd5) begin
            errors++;
            $display("FAIL time_frozen_in_stop: got %0d expected 5", bus.trip_time);
        end
        $display("trip_time: time=%0d state=%0d", bus.trip_time, bus.state_o);
    endtask

    task automatic test_zero_run();
        int seq [6] = '{8, 0, 0, 10, 0, 0};
        for (int i = 0; i < 6; i++) begin
            bus.speed = WIDTH'(seq[i]); bus.speed_vld = 1'b1;
            tick();
            tick(); // idle cycle: must not touch the zero run
            checks++;
            if (bus.state_o !== 2'd1) begin
                errors++;
                $display("FAIL zero_run_broken[%0d]: got state=%0d expected 1", i, bus.state_o);
            end
        end
        bus.speed = '0; bus.speed_vld = 1'b1;
        tick();
        checks++;
        if (bus.state_o !== 2'd0) begin
            errors++;
            $display("FAIL zero_run_stop: got state=%0d expected 0", bus.state_o);
        end
        $display("zero_run: state=%0d", bus.state_o);
    endtask

    task automatic test_clear();
        int hi;
        int sel_before;
        bus.btn_clr = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        bus.speed = 12'd40; bus.speed_vld = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            bus.tick_1s = 1'b1;
            tick();
        end
        tick();
        checks++;
        if (bus.trip_time !== 16'd7 || bus.max_val !== 12'd40) begin
            errors++;
            $display("FAIL clear_setup: got time=%0d max=%0d expected 7 and 40", bus.trip_time, bus.max_val);
        end
        sel_before = m_sel;
        hi = 0;
        bus.btn_clr = 1'b1; bus.speed = 12'd30; bus.speed_vld = 1'b1;
        bus.tick_1s = 1'b1; bus.btn_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.trk_r === 1'b1) hi++;
            checks++;
            if (bus.trk_speed !== '0 || bus.trip_time !== '0 ||
                bus.state_o !== 2'((i < CLR_CYC) ? 2 : 0)) begin
                errors++;
                $display("FAIL clear_cycle[%0d]: got trk_speed=%0d time=%0d state=%0d expected 0,0,%0d",
                         i, bus.trk_speed, bus.trip_time, bus.state_o, (i < CLR_CYC) ? 2 : 0);
            end
        end
        checks++;
        if (hi != CLR_CYC || bus.max_val !== '0 || bus.disp_sel !== 2'(sel_before)) begin
            errors++;
            $display("FAIL clear_pulse: got trk_r cycles=%0d max=%0d sel=%0d expected %0d,0,%0d",
                     hi, bus.max_val, bus.disp_sel, CLR_CYC, sel_before);
        end
        $display("clear: trk_r cycles=%0d state=%0d", hi, bus.state_o);
    endtask

    task automatic test_mode();
        int start;
        int held;
        start = m_sel;
        for (int k = 1; k <= 4; k++) begin
            bus.btn_mode = 1'b1;
            tick();
            tick();
            checks++;
            if (bus.disp_sel !== 2'((start + k) % 3)) begin
                errors++;
                $display("FAIL mode_step[%0d]: got %0d expected %0d", k, bus.disp_sel, (start + k) % 3);
            end
        end
        held = (start + 4) % 3;
        bus.btn_clr = 1'b1;
        tick();
        bus.btn_mode = 1'b1;
        tick();
        checks++;
        if (bus.disp_sel !== 2'(held) || bus.state_o !== 2'd2) begin
            errors++;
            $display("FAIL mode_in_clear: got sel=%0d state=%0d expected %0d and 2", bus.disp_sel, bus.state_o, held);
        end
        for (int i = 0; i < 3; i++) tick();
        $display("mode: disp_sel=%0d", bus.disp_sel);
    endtask

    task automatic test_saturate();
        bus.speed = 12'd50; bus.speed_vld = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.tick_1s = 1'b1;
            tick();
            checks++;
            if (bus4.trip_time !== TW4'(m_time4)) begin
                errors++;
                $display("FAIL sat_step[%0d]: got %0d expected %0d", i, bus4.trip_time, m_time4);
            end
        end
        checks++;
        if (bus4.trip_time !== 4'd15 || bus.trip_time !== 16'd20) begin
            errors++;
            $display("FAIL saturate: got narrow=%0d wide=%0d expected 15 and 20", bus4.trip_time, bus.trip_time);
        end
        bus.btn_clr = 1'b1;
        tick();
        r = 1'b1;
        tick();
        checks++;
        if (bus.state_o !== 2'd0 || bus.trk_r !== 1'b0 || bus.trk_speed !== '0 ||
            bus.trip_time !== '0 || bus.disp_sel !== 2'd0 || bus.disp_val !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear: got state=%0d trk_r=%0d trk_speed=%0d time=%0d sel=%0d val=%0d expected all 0",
                     bus.state_o, bus.trk_r, bus.trk_speed, bus.trip_time, bus.disp_sel, bus.disp_val);
        end
        $display("saturate: narrow=%0d then reset state=%0d", m_time4, bus.state_o);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.speed     = ($urandom_range(0, 9) < 3) ? '0 : WIDTH'($urandom_range(1, 4095));
            bus.speed_vld = ($urandom_range(0, 9) < 4);
            bus.tick_1s   = ($urandom_range(0, 9) < 3);
            bus.btn_mode  = ($urandom_range(0, 9) < 1);
            bus.btn_clr   = ($urandom_range(0, 49) < 1);
            r             = ($urandom_range(0, 199) < 1);
            tick();
            checks++;
            if (bus.state_o !== 2'(m_state) || bus.trk_speed !== WIDTH'(m_spd) ||
                bus.trk_r !== (m_state == 2) || bus.trip_time !== TIME_W'(m_time) ||
                bus.disp_sel !== 2'(m_sel) || bus.disp_val !== TIME_W'(m_disp) ||
                bus.max_val !== WIDTH'(m_max) || bus4.trip_time !== TW4'(m_time4)) begin
                errors++;
                $display("FAIL random[%0d]: got st=%0d spd=%0d trk_r=%0d t=%0d sel=%0d val=%0d max=%0d t4=%0d expected %0d %0d %0d %0d %0d %0d %0d %0d",
                         i, bus.state_o, bus.trk_speed, bus.trk_r, bus.trip_time, bus.disp_sel,
                         bus.disp_val, bus.max_val, bus4.trip_time, m_state, m_spd, (m_state == 2),
                         m_time, m_sel, m_disp, m_max, m_time4);
            end
        end
        $display("random: 400 cycles, final state=%0d time=%0d", bus.state_o, bus.trip_time);
    endtask

    initial begin
        r = 1'b1;
        bus.speed = '0; bus.speed_vld = 1'b0; bus.tick_1s = 1'b0;
        bus.btn_mode = 1'b0; bus.btn_clr = 1'b0;
        test_reset();
        test_ride_start();
        test_trip_time();
        test_zero_run();
        test_clear();
        test_mode();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
